// File: rtl/tdc_evarb_pkg.sv
// Shared constants for the TDC event arbiter: CSR word map, bit positions and FIFO entry layout.
package tdc_evarb_pkg;

    localparam int TS_W  = 32;
    localparam int CH_W  = 3;
    localparam int POL_W = 1;

    localparam logic [9:0] REG_CTRL    = 10'd0;
    localparam logic [9:0] REG_STATUS  = 10'd1;
    localparam logic [9:0] REG_TS      = 10'd2;
    localparam logic [9:0] REG_TAG     = 10'd3;
    localparam logic [9:0] REG_DROPCNT = 10'd4;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_IRQEN    = 1;
    localparam int CTRL_MASK_LSB = 8;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_LEVEL_LSB = 8;
    localparam int STAT_LEVEL_W   = 5;
    localparam int STAT_OVF_LSB   = 16;

    localparam int TAG_POL = 8;

    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [CH_W-1:0]  ch;
        logic [POL_W-1:0] pol;
    } entry_t;

endpackage

// File: rtl/tdc_evarb_if.sv
// CSR bus plus per-channel event handshake. An event is consumed on the clock edge where its ack is high.
interface tdc_evarb_if #(parameter int nchannels = 2);

    logic [13:0]             csr_a;
    logic                    csr_we;
    logic [31:0]             csr_di;
    logic [31:0]             csr_do;
    logic [nchannels-1:0]    ev_stb_i;
    logic [32*nchannels-1:0] ev_ts_i;
    logic [nchannels-1:0]    ev_pol_i;
    logic [nchannels-1:0]    ev_ack_o;
    logic                    irq;

    modport master (
        output csr_a, csr_we, csr_di, ev_stb_i, ev_ts_i, ev_pol_i,
        input  csr_do, ev_ack_o, irq
    );

    modport slave (
        input  csr_a, csr_we, csr_di, ev_stb_i, ev_ts_i, ev_pol_i,
        output csr_do, ev_ack_o, irq
    );

endinterface

// File: rtl/tdc_evarb_fifo.sv
// Synchronous event FIFO; head is registered and already reflects this cycle's push/pop on the next cycle.
module tdc_evarb_fifo
    import tdc_evarb_pkg::*;
#(
    parameter int depth_log2 = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  entry_t              push_data,
    output entry_t              head,
    output logic                full,
    output logic                empty,
    output logic [depth_log2:0] level
);

    localparam int DEPTH = 1 << depth_log2;

    entry_t                mem [DEPTH];
    logic [depth_log2-1:0] rd_ptr;
    logic [depth_log2-1:0] wr_ptr;
    logic [depth_log2-1:0] rd_next;
    logic [depth_log2:0]   level_next;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (level == (depth_log2+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_next = do_pop ? rd_ptr + depth_log2'(1) : rd_ptr;

    always_comb begin
        level_next = level;
        case ({do_push, do_pop})
            2'b10:   level_next = level + (depth_log2+1)'(1);
            2'b01:   level_next = level - (depth_log2+1)'(1);
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            head   <= '0;
        end else begin
            rd_ptr <= rd_next;
            level  <= level_next;
            if (do_push) wr_ptr <= wr_ptr + depth_log2'(1);
            // A write landing on the new head slot has not reached mem yet, so bypass it.
            if (level_next == '0)
                head <= '0;
            else if (do_push && rd_next == wr_ptr)
                head <= push_data;
            else
                head <= mem[rd_next];
        end
    end

endmodule

// File: rtl/tdc_evarb.sv
// Round-robin TDC event arbiter feeding a CSR-drained FIFO with level interrupt.
// Optional TDC_EVARB_DROPCNT_EN adds a saturating full-drop counter at CSR word 4.
module tdc_evarb
    import tdc_evarb_pkg::*;
#(
    parameter logic [3:0] csr_addr   = 4'h2,
    parameter int         nchannels  = 2,
    parameter int         depth_log2 = 4
) (
    input logic        sys_clk,
    input logic        sys_rst,
    tdc_evarb_if.slave bus
);

    logic [CH_W-1:0]     rr;
    logic [CH_W-1:0]     grant;
    logic                any_req;
    logic [7:0]          req8;
    int                  scan_idx;
    entry_t              ev_sel;
    entry_t              head;
    logic                full;
    logic                empty;
    logic [depth_log2:0] level;
    logic                ctrl_en;
    logic                irqen;
    logic [7:0]          mask;
    logic [7:0]          ovf;
    logic                sel;
    logic                wr;
    logic [9:0]          word;
    logic                ch_en;
    logic                push;
    logic                pop;
    logic                drop_full;
    logic [31:0]         rd_data;
    logic [15:0]         dropcnt_rd;
    logic                unused_di;

    assign sel       = (bus.csr_a[13:10] == csr_addr);
    assign word      = bus.csr_a[9:0];
    assign wr        = sel & bus.csr_we;
    assign pop       = wr && (word == REG_TAG);
    assign unused_di = ^{bus.csr_di[31:24], bus.csr_di[7:2]};

    // Scan downward so the channel closest to rr (lowest offset) is the last, winning assignment.
    assign req8 = 8'(bus.ev_stb_i);
    always_comb begin
        any_req  = 1'b0;
        grant    = '0;
        scan_idx = 0;
        for (int k = nchannels - 1; k >= 0; k--) begin
            scan_idx = int'(rr) + k;
            if (scan_idx >= nchannels) scan_idx = scan_idx - nchannels;
            if (req8[scan_idx[2:0]]) begin
                any_req = 1'b1;
                grant   = scan_idx[CH_W-1:0];
            end
        end
    end

    always_comb begin
        ev_sel    = '0;
        ev_sel.ch = grant;
        for (int i = 0; i < nchannels; i++) begin
            if (grant == CH_W'(i)) begin
                ev_sel.ts  = bus.ev_ts_i[32*i +: 32];
                ev_sel.pol = bus.ev_pol_i[i];
            end
        end
    end

    assign bus.ev_ack_o = (any_req && !sys_rst) ? (nchannels'(1) << grant) : '0;
    assign ch_en        = ctrl_en & mask[grant];
    assign push         = any_req & ch_en & ~full;
    assign drop_full    = any_req & ch_en & full;
    assign bus.irq      = irqen & ~empty;

    tdc_evarb_fifo #(.depth_log2(depth_log2)) u_fifo (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .push      (push),
        .pop       (pop),
        .push_data (ev_sel),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rr      <= '0;
            ctrl_en <= 1'b0;
            irqen   <= 1'b0;
            mask    <= '0;
            ovf     <= '0;
        end else begin
            if (any_req) rr <= (grant == CH_W'(nchannels - 1)) ? '0 : grant + CH_W'(1);
            if (wr && word == REG_CTRL) begin
                ctrl_en <= bus.csr_di[CTRL_EN];
                irqen   <= bus.csr_di[CTRL_IRQEN];
                mask    <= bus.csr_di[CTRL_MASK_LSB +: 8];
            end
            // A new overflow outranks a same-cycle software clear.
            ovf <= (ovf & ~((wr && word == REG_STATUS) ? bus.csr_di[STAT_OVF_LSB +: 8] : 8'd0))
                 | (drop_full ? (8'd1 << grant) : 8'd0);
        end
    end

`ifdef TDC_EVARB_DROPCNT_EN
    logic [15:0] dropcnt;
    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            dropcnt <= '0;
        else if (wr && word == REG_DROPCNT)
            dropcnt <= '0;
        else if (drop_full && dropcnt != 16'hffff)
            dropcnt <= dropcnt + 16'd1;
    end
    assign dropcnt_rd = dropcnt;
`else
    assign dropcnt_rd = 16'd0;
`endif

    always_comb begin
        rd_data = '0;
        case (word)
            REG_CTRL: begin
                rd_data[CTRL_EN]             = ctrl_en;
                rd_data[CTRL_IRQEN]          = irqen;
                rd_data[CTRL_MASK_LSB +: 8]  = mask;
            end
            REG_STATUS: begin
                rd_data[STAT_EMPTY]                      = empty;
                rd_data[STAT_FULL]                       = full;
                rd_data[STAT_LEVEL_LSB +: STAT_LEVEL_W]  = STAT_LEVEL_W'(level);
                rd_data[STAT_OVF_LSB +: 8]               = ovf;
            end
            REG_TS:  rd_data = head.ts;
            REG_TAG: begin
                rd_data[CH_W-1:0] = head.ch;
                rd_data[TAG_POL]  = head.pol[0];
            end
            REG_DROPCNT: rd_data[15:0] = dropcnt_rd;
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) bus.csr_do <= '0;
        else         bus.csr_do <= sel ? rd_data : 32'd0;
    end

endmodule

// File: tb/tb_tdc_evarb.sv
// Self-checking bench for tdc_evarb: directed scenarios plus randomized traffic against a queue-based model.
module tb_tdc_evarb;

    localparam int         NCH   = 2;
    localparam int         DEPTH = 16;
    localparam int         W     = 36;
    localparam logic [3:0] BANK  = 4'h2;

    logic sys_clk;
    logic sys_rst;
    tdc_evarb_if #(.nchannels(NCH)) bus ();

    tdc_evarb #(.csr_addr(BANK), .nchannels(NCH), .depth_log2(4)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard / model state ----------------
    logic [W-1:0] exp_q[$];
    int           m_rr;
    bit           m_en;
    bit           m_irqen;
    logic [7:0]   m_mask;
    logic [7:0]   m_ovf;
    int           m_drop;
    int           checks;
    int           passed;

    task automatic model_reset();
        exp_q.delete();
        m_rr = 0; m_en = 0; m_irqen = 0; m_mask = '0; m_ovf = '0; m_drop = 0;
    endtask

    task automatic tick();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic csr_write(input logic [9:0] word, input logic [31:0] data);
        bus.csr_a = {BANK, word}; bus.csr_we = 1'b1; bus.csr_di = data;
        tick();
        bus.csr_we = 1'b0;
        case (word)
            10'd0: begin m_en = data[0]; m_irqen = data[1]; m_mask = data[15:8]; end
            10'd1: m_ovf = m_ovf & ~data[23:16];
            10'd3: if (exp_q.size() > 0) void'(exp_q.pop_front());
            10'd4: m_drop = 0;
            default: ;
        endcase
    endtask

    task automatic csr_read(input logic [9:0] word, output logic [31:0] data);
        bus.csr_a = {BANK, word}; bus.csr_we = 1'b0;
        tick();
        data = bus.csr_do;
    endtask

    // One event cycle: drive requests (and optionally a pop), check the ack, advance the model.
    task automatic cycle(input logic [1:0] stb, input logic [63:0] ts, input logic [1:0] pol,
                         input bit do_pop, input string name, output logic [1:0] got);
        int         g;
        logic [1:0] exp_ack;
        bit         was_full;
        bit         exp_irq;
        bus.ev_stb_i = stb; bus.ev_ts_i = ts; bus.ev_pol_i = pol;
        bus.csr_a = {BANK, 10'd3}; bus.csr_we = do_pop; bus.csr_di = 32'h0;
        #1;
        g = -1;
        for (int k = 0; k < NCH; k++) begin
            int c;
            c = (m_rr + k) % NCH;
            if (g < 0 && stb[c]) g = c;
        end
        exp_ack = (g < 0) ? 2'b00 : 2'(1 << g);
        got = bus.ev_ack_o;
        checks++;
        if (got !== exp_ack) $display("FAIL %s ack: got %b expected %b", name, got, exp_ack);
        else passed++;
        tick();
        was_full = (exp_q.size() == DEPTH);
        if (do_pop && exp_q.size() > 0) void'(exp_q.pop_front());
        if (g >= 0) begin
            m_rr = (g + 1) % NCH;
            if (m_en && m_mask[g]) begin
                if (was_full) begin
                    m_ovf[g] = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end else begin
                    exp_q.push_back({ts[32*g +: 32], 3'(g), pol[g]});
                end
            end
        end
        bus.ev_stb_i = '0; bus.csr_we = 1'b0;
        exp_irq = m_irqen && (exp_q.size() > 0);
        checks++;
        if (bus.irq !== exp_irq) $display("FAIL %s irq: got %b expected %b", name, bus.irq, exp_irq);
        else passed++;
    endtask

    task automatic check_status(input string name);
        logic [31:0] v, e;
        csr_read(10'd1, v);
        e = {8'h0, m_ovf, 3'b0, 5'(exp_q.size()), 6'b0, exp_q.size() == DEPTH, exp_q.size() == 0};
        checks++;
        if (v !== e) $display("FAIL %s status: got %h expected %h", name, v, e);
        else passed++;
    endtask

    task automatic check_head(input string name);
        logic [31:0] v, e;
        csr_read(10'd2, v);
        e = (exp_q.size() > 0) ? exp_q[0][35:4] : 32'h0;
        checks++;
        if (v !== e) $display("FAIL %s ts: got %h expected %h", name, v, e);
        else passed++;
        csr_read(10'd3, v);
        e = (exp_q.size() > 0) ? {23'b0, exp_q[0][0], 5'b0, exp_q[0][3:1]} : 32'h0;
        checks++;
        if (v !== e) $display("FAIL %s tag: got %h expected %h", name, v, e);
        else passed++;
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < DEPTH + 2 && exp_q.size() > 0; n++) begin
            check_head(name);
            csr_write(10'd3, 32'h0);
        end
        check_status(name);
    endtask

    task automatic check_word(input logic [9:0] word, input logic [31:0] e, input string name);
        logic [31:0] v;
        csr_read(word, v);
        checks++;
        if (v !== e) $display("FAIL %s: got %h expected %h", name, v, e);
        else passed++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        sys_rst = 1'b1;
        bus.csr_a = '0; bus.csr_we = 1'b0; bus.csr_di = '0;
        bus.ev_stb_i = 2'b11; bus.ev_ts_i = '0; bus.ev_pol_i = '0;
        tick(); tick();
        #1;
        checks++;
        if (bus.ev_ack_o !== 2'b00) $display("FAIL reset_ack: got %b expected 00", bus.ev_ack_o);
        else passed++;
        bus.ev_stb_i = '0;
        sys_rst = 1'b0;
        model_reset();
        checks++;
        if (bus.csr_do !== 32'h0 || bus.irq !== 1'b0)
            $display("FAIL reset_outputs: csr_do %h irq %b expected 0 0", bus.csr_do, bus.irq);
        else passed++;
        check_word(10'd0, 32'h0, "reset_ctrl");
        check_word(10'd1, 32'h1, "reset_status");
        check_word(10'd2, 32'h0, "reset_ts");
        bus.csr_a = {4'h5, 10'd1};
        tick();
        checks++;
        if (bus.csr_do !== 32'h0) $display("FAIL other_bank: got %h expected 0", bus.csr_do);
        else passed++;
    endtask

    task automatic test_basic();
        logic [1:0] a;
        csr_write(10'd0, 32'h0301);
        check_word(10'd0, 32'h0301, "basic_ctrl");
        cycle(2'b01, {32'h0, 32'h0000_1234}, 2'b01, 0, "basic", a);
        check_word(10'd1, 32'h0000_0100, "basic_level");
        check_word(10'd2, 32'h0000_1234, "basic_ts");
        check_word(10'd3, 32'h0000_0100, "basic_tag");
        drain("basic_drain");
    endtask

    task automatic test_round_robin();
        logic [1:0] a, prev;
        for (int i = 0; i < 6; i++) begin
            cycle(2'b11, {$urandom, $urandom}, 2'($urandom), 0, "rr", a);
            if (i > 0) begin
                checks++;
                if (a === prev) $display("FAIL rr_alternate: got %b twice", a);
                else passed++;
            end
            prev = a;
        end
        drain("rr_drain");
    endtask

    task automatic test_overflow();
        logic [1:0] a;
        for (int i = 0; i < 17; i++) cycle(2'b10, {$urandom, $urandom}, 2'($urandom), 0, "ovf", a);
        check_word(10'd1, 32'h0002_1002, "ovf_status");
        check_status("ovf_model");
`ifdef TDC_EVARB_DROPCNT_EN
        check_word(10'd4, 32'd1, "ovf_dropcnt");
`else
        check_word(10'd4, 32'd0, "ovf_dropcnt");
`endif
        csr_write(10'd1, 32'h0002_0000);
        check_word(10'd1, 32'h0000_1002, "ovf_clear");
    endtask

    task automatic test_collision();
        logic [1:0] a;
        cycle(2'b01, {$urandom, $urandom}, 2'($urandom), 1, "collide", a);
        check_word(10'd1, 32'h0001_0F00, "collide_status");
`ifdef TDC_EVARB_DROPCNT_EN
        check_word(10'd4, 32'd2, "collide_dropcnt");
`else
        check_word(10'd4, 32'd0, "collide_dropcnt");
`endif
        csr_write(10'd1, 32'h00FF_0000);
        drain("collide_drain");
    endtask

    task automatic test_masking();
        logic [1:0] a;
        csr_write(10'd0, 32'h0201);
        cycle(2'b01, {$urandom, $urandom}, 2'b01, 0, "mask", a);
        check_word(10'd1, 32'h0000_0001, "mask_status");
    endtask

    task automatic test_random();
        logic [1:0] a;
        for (int i = 0; i < 300; i++) begin
            if (i % 50 == 0)
                csr_write(10'd0, {16'h0, 6'h0, 2'($urandom_range(1, 3)), 6'h0,
                                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)});
            cycle(2'($urandom), {$urandom, $urandom}, 2'($urandom), $urandom_range(0, 3) == 0, "rand", a);
            if (i % 25 == 24) begin
                check_status("rand_status");
                check_head("rand_head");
            end
        end
`ifdef TDC_EVARB_DROPCNT_EN
        check_word(10'd4, 32'(m_drop), "rand_dropcnt");
`else
        check_word(10'd4, 32'd0, "rand_dropcnt");
`endif
        csr_write(10'd1, 32'h00FF_0000);
        drain("rand_drain");
    endtask

    task automatic test_irq_reset();
        logic [1:0] a;
        csr_write(10'd0, 32'h0303);
        for (int i = 0; i < 3; i++) cycle(2'b01, {$urandom, $urandom}, 2'($urandom), 0, "irq_fill", a);
        checks++;
        if (bus.irq !== 1'b1) $display("FAIL irq_set: got %b expected 1", bus.irq);
        else passed++;
        sys_rst = 1'b1;
        bus.ev_stb_i = 2'b01;
        #1;
        checks++;
        if (bus.ev_ack_o !== 2'b00) $display("FAIL irq_rst_ack: got %b expected 00", bus.ev_ack_o);
        else passed++;
        tick();
        sys_rst = 1'b0;
        bus.ev_stb_i = '0;
        model_reset();
        checks++;
        if (bus.irq !== 1'b0) $display("FAIL irq_cleared: got %b expected 0", bus.irq);
        else passed++;
        check_word(10'd1, 32'h0000_0001, "irq_rst_status");
        check_word(10'd0, 32'h0, "irq_rst_ctrl");
        csr_write(10'd0, 32'h0301);
        cycle(2'b11, {$urandom, $urandom}, 2'($urandom), 0, "post_rst_rr", a);
        drain("post_rst_drain");
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_basic();
        test_round_robin();
        test_overflow();
        test_collision();
        test_masking();
        test_random();
        test_irq_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
